boot_loader: RTL and testbench
==============================

// Module: boot_loader
// PURPOSE
//  Byte-stream program loader: the writer side of the unified instruction/data memory.
//  Receives a length header and big-endian instruction words over a valid/ready byte
//  stream, and writes the words into memory through the same port the processor uses.
//  Holds the processor in reset until the load completes.
//  Top level muxes mem we/a/wd between loader and processor on cpu_reset.
// PARAMETERS
//  DEPTH_WORDS  64   memory capacity in 32-bit words; largest legal header value
//  BASE_ADDR    0    byte address of the first word written (word aligned)
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  reset      in   1   synchronous, active-high
//  start      in   1   one-cycle pulse that begins a load; honoured only in IDLE
//  in_data    in   8   stream byte
//  in_valid   in   1   in_data holds a valid byte
//  in_ready   out  1   loader accepts a byte this cycle (transfer = in_valid & in_ready)
//  mem_we     out  1   memory write enable
//  mem_adr    out  32  memory byte address
//  mem_wd     out  32  memory write data
//  cpu_reset  out  1   processor reset; high until DONE
//  busy       out  1   high in HDR/DATA/WRITE/CHECK
//  done       out  1   load completed successfully (sticky until reset)
//  error      out  1   load aborted (sticky until reset)
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=0, mem_we=0, mem_adr=BASE_ADDR, mem_wd=0,
//   cpu_reset=1, busy=0, done=0, error=0. Internal word counter and byte counter = 0.
//  IDLE:  in_ready=0. On start -> HDR. start is ignored in every other state.
//  HDR:   in_ready=1. Transfer captures N=in_data.
//   N==0 or N>DEPTH_WORDS -> ERR. Otherwise -> DATA with byte_cnt=0 and word_idx=0.
//  DATA:  in_ready=1. Each transfer does buf={buf[23:0],in_data} and byte_cnt++.
//   The first byte is the MSB. After the 4th transfer -> WRITE.
//  WRITE: in_ready=0 and mem_we=1 for exactly one cycle.
//   mem_adr=BASE_ADDR+4*word_idx; mem_wd=buf.
//   If word_idx==N-1 -> CHECK (CHECKSUM_EN) or DONE. Otherwise word_idx++, byte_cnt=0 -> DATA.
//  DONE:  cpu_reset=0, done=1, in_ready=0, mem_we=0. Terminal until reset.
//  ERR:   cpu_reset=1, error=1, in_ready=0, mem_we=0. Terminal until reset.
//   Words already written stay in memory.
//  Throughput: 5 cycles/word minimum (4 byte transfers + 1 write cycle). in_valid gaps
//   only stall; byte/word counters never advance without a transfer.
//  mem_we is never high outside WRITE. mem_adr/mem_wd hold their last values otherwise.
//  Reset in any state, including mid-word: returns to IDLE next edge, no write for the
//   partial word, cpu_reset=1, done/error cleared.
//  start and a transfer in the same IDLE cycle: the byte is not accepted (in_ready=0).
// CONFIGURATION
//  CHECKSUM_EN defined: after the Nth WRITE, state CHECK takes one more byte (in_ready=1).
//   Requirement: (sum of all 4N data bytes + check byte) mod 256 == 0.
//   Pass -> DONE; fail -> ERR. A running 8-bit sum accumulates on every DATA transfer.
//  CHECKSUM_EN undefined: no CHECK state, no sum register; last WRITE -> DONE.
// TESTING
//  1 Load: start; bytes 02,20,02,00,05,AC,02,00,54 -> mem_we pulses write 0x20020005@0x0
//    then 0xAC020054@0x4; done=1, cpu_reset=0 the cycle after the second write.
//  2 Bad header: 00 -> error=1, no mem_we ever; header 0x41 (65, DEPTH_WORDS=64) -> error=1;
//    cpu_reset stays 1 in both cases.
//  3 Backpressure: same stream as 1 with random in_valid gaps -> identical writes;
//    in_ready=0 on every WRITE cycle, so no byte is lost or duplicated.
//  4 Reset mid-word: after header 01 and bytes 12,34, pulse reset -> IDLE, no mem_we;
//    then start, 01,DE,AD,BE,EF -> 0xDEADBEEF@BASE_ADDR, done=1.
//  5 Start ignored: start pulsed during DATA and in DONE -> no state change, no extra write.
//  6 CHECKSUM_EN: 01,01,02,03,04,F6 -> done=1; same stream with check byte F5 ->
//    0x01020304 is written, then error=1 and cpu_reset=1.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: byte-stream program loader, writer side of the unified
// instruction/data memory. Receives a length header N followed by N
// big-endian 32-bit words on a valid/ready byte stream and writes them to
// consecutive word addresses starting at BASE_ADDR. Holds the processor in
// reset until the load completes.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      synchronous active-high reset
//   start      one-cycle pulse that begins a load, honoured only in IDLE
//   in_data    stream byte
//   in_valid   in_data holds a valid byte
//   in_ready   loader accepts a byte this cycle
//   mem_we     memory write enable (one cycle per word)
//   mem_adr    memory byte address
//   mem_wd     memory write data
//   cpu_reset  processor reset, high until the load is done
//   busy       load in progress
//   done       load completed (sticky until reset)
//   error      load aborted (sticky until reset)
//
// Optional feature: define CHECKSUM_EN to require a trailing check byte such
// that the 8-bit sum of all data bytes plus the check byte is zero.

module boot_loader #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wd,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int unsigned ByteCntW = 2;
   localparam int unsigned WordW    = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_WRITE,
`ifdef CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE,
      S_ERR
   } state_e;

   state_e              state_q, state_d;
   logic [WordW-1:0]    n_q, n_d;
   logic [WordW-1:0]    word_q, word_d;
   logic [ByteCntW-1:0] byte_q, byte_d;
   logic [23:0]         buf_q, buf_d;       // first three bytes of the current word
   logic [31:0]         adr_q, adr_d;
   logic [31:0]         wd_q, wd_d;
   logic                in_ready_q, in_ready_d;
   logic                mem_we_q, mem_we_d;
   logic                cpu_reset_q, cpu_reset_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                xfer_c;
`ifdef CHECKSUM_EN
   logic [7:0]          sum_q, sum_d;
`endif

   assign xfer_c = in_valid & in_ready_q;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         word_q      <= '0;
         byte_q      <= '0;
         buf_q       <= '0;
         adr_q       <= BASE_ADDR;
         wd_q        <= '0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         word_q      <= word_d;
         byte_q      <= byte_d;
         buf_q       <= buf_d;
         adr_q       <= adr_d;
         wd_q        <= wd_d;
         in_ready_q  <= in_ready_d;
         mem_we_q    <= mem_we_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
`ifdef CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   // Next state; outputs are decoded from the next state so they are
   // registered yet line up with the state they describe.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      word_d  = word_q;
      byte_d  = byte_q;
      buf_d   = buf_q;
      adr_d   = adr_q;
      wd_d    = wd_q;
`ifdef CHECKSUM_EN
      sum_d   = sum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_HDR;
         end
         S_HDR: begin
            if (xfer_c) begin
               n_d    = in_data;
               word_d = '0;
               byte_d = '0;
`ifdef CHECKSUM_EN
               sum_d  = '0;
`endif
               if (in_data == 8'd0 || 32'(in_data) > DEPTH_WORDS) state_d = S_ERR;
               else                                               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer_c) begin
               buf_d  = {buf_q[15:0], in_data};
               byte_d = ByteCntW'(byte_q + ByteCntW'(1));
`ifdef CHECKSUM_EN
               sum_d  = 8'(sum_q + in_data);
`endif
               // Fourth byte completes the word: latch address and data for WRITE
               if (byte_q == ByteCntW'(3)) begin
                  state_d = S_WRITE;
                  adr_d   = BASE_ADDR + {22'd0, word_q, 2'b00};
                  wd_d    = {buf_q, in_data};
               end
            end
         end
         S_WRITE: begin
            if (word_q == WordW'(n_q - WordW'(1))) begin
`ifdef CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else begin
               word_d  = WordW'(word_q + WordW'(1));
               byte_d  = '0;
               state_d = S_DATA;
            end
         end
`ifdef CHECKSUM_EN
         S_CHECK: begin
            if (xfer_c) begin
               if (8'(sum_q + in_data) == 8'd0) state_d = S_DONE;
               else                             state_d = S_ERR;
            end
         end
`endif
         S_DONE: ;
         S_ERR:  ;
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_HDR) || (state_d == S_DATA)
`ifdef CHECKSUM_EN
                    || (state_d == S_CHECK)
`endif
                    ;
      mem_we_d    = (state_d == S_WRITE);
      busy_d      = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_WRITE)
`ifdef CHECKSUM_EN
                    || (state_d == S_CHECK)
`endif
                    ;
      done_d      = (state_d == S_DONE);
      error_d     = (state_d == S_ERR);
      cpu_reset_d = (state_d != S_DONE);
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_adr   = adr_q;
   assign mem_wd    = wd_q;
   assign cpu_reset = cpu_reset_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader: directed and randomized loads checked against a
// stream-level model of what the memory should receive.

module tb_boot_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready, mem_we, cpu_reset, busy, done, error;
   logic [31:0] mem_adr, mem_wd;

   boot_loader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mem_we   (mem_we),
      .mem_adr  (mem_adr),
      .mem_wd   (mem_wd),
      .cpu_reset(cpu_reset),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Write monitor: records every memory write and when done rises
   logic [31:0] got_adr[$];
   logic [31:0] got_wd[$];
   int          cyc = 0;
   int          last_we_cyc = -1;
   int          done_cyc = -1;
   logic        done_prev = 1'b0;

   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_we) begin
         got_adr.push_back(mem_adr);
         got_wd.push_back(mem_wd);
         last_we_cyc = cyc;
         check_eq("we_rdy", 32'(in_ready), 32'd0);
      end
      if (done && !done_prev) done_cyc = cyc;
      done_prev = done;
   end

   task automatic send_byte(input logic [7:0] b, input bit bp);
      int tries = 0;
      if (bp) begin
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && tries < 100) begin
         @(negedge clk);
         tries++;
      end
      if (!in_ready) check_eq("rdy_timeout", 32'(in_ready), 32'd1);
      else           @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_rdy",  32'(in_ready),  32'd0);
      check_eq("rst_we",   32'(mem_we),    32'd0);
      check_eq("rst_adr",  mem_adr,        32'd0);
      check_eq("rst_wd",   mem_wd,         32'd0);
      check_eq("rst_cpu",  32'(cpu_reset), 32'd1);
      check_eq("rst_busy", 32'(busy),      32'd0);
      check_eq("rst_done", 32'(done),      32'd0);
      check_eq("rst_err",  32'(error),     32'd0);
      reset = 1'b0;
   endtask

   // mode: 0 plain, 1 start pulsed mid-DATA, 2 start with a byte in IDLE, 3 no reset first
   task automatic run_load(input logic [7:0] hdr, input logic [31:0] words[$],
                           input bit ck_ok, input bit bp, input int mode);
      logic [7:0] s[$];
      logic [7:0] sum = 8'h00;
      bit         bad, exp_done;
      int         nexp;

      bad = (hdr == 8'd0) || (int'(hdr) > 64);
      s.push_back(hdr);
      if (!bad) begin
         foreach (words[i]) begin
            for (int k = 3; k >= 0; k--) begin
               s.push_back(words[i][8*k +: 8]);
               sum = 8'(sum + words[i][8*k +: 8]);
            end
         end
      end
      exp_done = !bad;
`ifdef CHECKSUM_EN
      if (!bad) s.push_back(ck_ok ? 8'(8'd0 - sum) : 8'(8'd0 - sum - 8'd1));
      exp_done = !bad && ck_ok;
`else
      if (ck_ok && sum == 8'hFF) exp_done = !bad;
`endif
      nexp = bad ? 0 : words.size();

      if (mode != 3) do_reset();
      got_adr.delete();
      got_wd.delete();
      done_cyc    = -1;
      last_we_cyc = -1;

      start = 1'b1;
      if (mode == 2) begin
         in_valid = 1'b1;
         in_data  = 8'h00;
         check_eq("idle_rdy", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;

      foreach (s[i]) begin
         if (mode == 1 && i == 2) start = 1'b1;
         send_byte(s[i], bp);
         start = 1'b0;
      end
      repeat (4) @(negedge clk);

      check_eq("n_writes", 32'(got_adr.size()), 32'(nexp));
      for (int i = 0; i < nexp && i < got_adr.size(); i++) begin
         check_eq("wr_adr", got_adr[i], 32'(4 * i));
         check_eq("wr_data", got_wd[i], words[i]);
      end
      check_eq("done",  32'(done),      32'(exp_done));
      check_eq("error", 32'(error),     32'(!exp_done));
      check_eq("cpu",   32'(cpu_reset), 32'(!exp_done));
      check_eq("busy",  32'(busy),      32'd0);
      check_eq("rdy",   32'(in_ready),  32'd0);
      if (!bad) check_eq("wd_hold", mem_wd, words[words.size()-1]);
`ifndef CHECKSUM_EN
      if (exp_done) check_eq("done_lat", 32'(done_cyc), 32'(last_we_cyc + 1));
`endif
   endtask

   initial begin
      logic [31:0] w[$];
      logic [7:0]  hdr;
      int          r;

      // Program load, then with random valid gaps, then with start pulsed mid-DATA
      w = {32'h20020005, 32'hAC020054};
      run_load(8'd2, w, 1'b1, 1'b0, 0);
      run_load(8'd2, w, 1'b1, 1'b1, 0);
      run_load(8'd2, w, 1'b1, 1'b0, 1);

      // start while DONE: nothing changes
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("done_start_wr",   32'(got_adr.size()), 32'd2);
      check_eq("done_start_done", 32'(done),           32'd1);
      check_eq("done_start_rdy",  32'(in_ready),       32'd0);

      // Bad headers
      w = {};
      run_load(8'h00, w, 1'b1, 1'b0, 0);
      run_load(8'h41, w, 1'b1, 1'b0, 0);

      // start with a byte offered in IDLE: that byte must not become the header
      w = {32'h11223344};
      run_load(8'd1, w, 1'b1, 1'b0, 2);

      // Reset mid-word, then a fresh load without an extra reset
      do_reset();
      got_adr.delete();
      got_wd.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h01, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("mid_wr",   32'(got_adr.size()), 32'd0);
      check_eq("mid_busy", 32'(busy),           32'd0);
      check_eq("mid_cpu",  32'(cpu_reset),      32'd1);
      w = {32'hDEADBEEF};
      run_load(8'd1, w, 1'b1, 1'b0, 3);

`ifdef CHECKSUM_EN
      w = {32'h01020304};
      run_load(8'd1, w, 1'b1, 1'b0, 0);
      run_load(8'd1, w, 1'b0, 1'b0, 0);
`endif

      // Randomized loads
      for (int it = 0; it < 12; it++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      hdr = 8'd0;
         else if (r == 1) hdr = 8'($urandom_range(65, 255));
         else             hdr = 8'($urandom_range(1, 6));
         w = {};
         if (r > 1) begin
            for (int i = 0; i < int'(hdr); i++) w.push_back($urandom);
         end
         run_load(hdr, w, ($urandom % 3) != 0, ($urandom % 2) != 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
